// File: rtl/cpu_pkg.sv
// Shared decode constants and EX-stage control types for the pipelined MIPS core.
// Opcode/funct values cover the small instruction subset the issue stage understands.
package cpu_pkg;

    localparam logic [3:0] ALU_NOP = 4'b0000;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_LUI = 4'b1000;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;

    typedef struct packed {
        logic valid;
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
    } ex_ctrl_t;

    typedef enum logic [1:0] {
        B_ZERO,
        B_RT,
        B_ZEXT,
        B_SEXT
    } b_sel_e;

    function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/ex_issue_fwd_mux.sv
// 32-bit forwarding selector: picks EX, then MEM, then WB, then register-file data.
// Register 0 is hardwired to zero and never forwarded.
module fwd_mux (
    input  logic [4:0]  src,
    input  logic [31:0] rf_data,
    input  logic        ex_en,
    input  logic [4:0]  ex_rd,
    input  logic [31:0] ex_data,
    input  logic        mem_en,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_data,
    input  logic        wb_en,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic [31:0] data
);

    always_comb begin
        data = rf_data;
        if (src == 5'd0)
            data = 32'd0;
        else if (ex_en && ex_rd == src)
            data = ex_data;
        else if (mem_en && mem_rd == src)
            data = mem_data;
        else if (wb_en && wb_rd == src)
            data = wb_data;
    end

endmodule

// File: rtl/ex_issue.sv
// Execute-stage issue: decodes the ID instruction, forwards operands, detects
// load-use hazards and registers the result into the ID/EX pipeline register.
module ex_issue
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [31:0] id_instr,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [31:0] alu_c,
    input  logic        mem_reg_write,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_result,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_result,
    input  logic        stall,
    input  logic        flush,
    output logic        hazard_stall,
    output logic        ex_valid,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_branch,
    output logic [3:0]  ex_alu_op,
    output logic [31:0] ex_a,
    output logic [31:0] ex_b,
    output logic [4:0]  ex_rd,
    output logic [31:0] ex_store_data
);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd_field;
    logic [15:0] imm;

    assign opcode   = id_instr[31:26];
    assign rs       = id_instr[25:21];
    assign rt       = id_instr[20:16];
    assign rd_field = id_instr[15:11];
    assign funct    = id_instr[5:0];
    assign imm      = id_instr[15:0];

    ex_ctrl_t    ctrl_q;
    logic [3:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [4:0]  rd_q;
    logic [31:0] sd_q;

    ex_ctrl_t    dec_ctrl;
    logic [3:0]  dec_op;
    b_sel_e      dec_b_sel;
    logic [4:0]  dec_rd;
    logic        dec_rt_used;
    logic        dec_known;
    logic        dec_store;

    // Unknown encodings fall through as a valid bubble with no side effects.
    always_comb begin
        dec_ctrl       = '0;
        dec_ctrl.valid = 1'b1;
        dec_op         = ALU_NOP;
        dec_b_sel      = B_ZERO;
        dec_rd         = 5'd0;
        dec_rt_used    = 1'b0;
        dec_known      = 1'b1;
        dec_store      = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                if (funct == FN_ADDU || funct == FN_SUBU) begin
                    dec_op             = (funct == FN_ADDU) ? ALU_ADD : ALU_SUB;
                    dec_b_sel          = B_RT;
                    dec_rd             = rd_field;
                    dec_rt_used        = 1'b1;
                    dec_ctrl.reg_write = 1'b1;
                end else begin
                    dec_known = 1'b0;
                end
            end
            OP_ORI, OP_LUI: begin
                dec_op             = (opcode == OP_ORI) ? ALU_OR : ALU_LUI;
                dec_b_sel          = B_ZEXT;
                dec_rd             = rt;
                dec_ctrl.reg_write = 1'b1;
            end
            OP_LW: begin
                dec_op             = ALU_ADD;
                dec_b_sel          = B_SEXT;
                dec_rd             = rt;
                dec_ctrl.mem_read  = 1'b1;
                dec_ctrl.reg_write = 1'b1;
            end
            OP_SW: begin
                dec_op             = ALU_ADD;
                dec_b_sel          = B_SEXT;
                dec_rt_used        = 1'b1;
                dec_store          = 1'b1;
                dec_ctrl.mem_write = 1'b1;
            end
            OP_BEQ: begin
                dec_op          = ALU_SUB;
                dec_b_sel       = B_RT;
                dec_rt_used     = 1'b1;
                dec_ctrl.branch = 1'b1;
            end
            default: dec_known = 1'b0;
        endcase
    end

    logic        ex_fwd_en;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] st_val;

    // A load in EX has no result yet, so it must not forward alu_c.
    assign ex_fwd_en = ctrl_q.valid & ctrl_q.reg_write & ~ctrl_q.mem_read;

    fwd_mux u_fwd_rs (
        .src(rs), .rf_data(id_rs_data),
        .ex_en(ex_fwd_en), .ex_rd(rd_q), .ex_data(alu_c),
        .mem_en(mem_reg_write), .mem_rd(mem_rd), .mem_data(mem_result),
        .wb_en(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_result),
        .data(rs_val)
    );

    fwd_mux u_fwd_rt (
        .src(rt), .rf_data(id_rt_data),
        .ex_en(ex_fwd_en), .ex_rd(rd_q), .ex_data(alu_c),
        .mem_en(mem_reg_write), .mem_rd(mem_rd), .mem_data(mem_result),
        .wb_en(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_result),
        .data(rt_val)
    );

    fwd_mux u_fwd_st (
        .src(rt), .rf_data(id_rt_data),
        .ex_en(ex_fwd_en), .ex_rd(rd_q), .ex_data(alu_c),
        .mem_en(mem_reg_write), .mem_rd(mem_rd), .mem_data(mem_result),
        .wb_en(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_result),
        .data(st_val)
    );

    logic [31:0] b_val;

    always_comb begin
        b_val = 32'd0;
        case (dec_b_sel)
            B_RT:    b_val = rt_val;
            B_ZEXT:  b_val = {16'd0, imm};
            B_SEXT:  b_val = sign_ext16(imm);
            default: b_val = 32'd0;
        endcase
    end

    logic hazard;

    assign hazard = ctrl_q.valid & ctrl_q.mem_read & (rd_q != 5'd0) & id_valid &
                    ((rs == rd_q) | (dec_rt_used & (rt == rd_q)));
    assign hazard_stall = hazard & ~flush & ~rst;

    // Flush beats stall; stall beats the hazard bubble.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ctrl_q <= '0;
            op_q   <= ALU_NOP;
            a_q    <= 32'd0;
            b_q    <= 32'd0;
            rd_q   <= 5'd0;
            sd_q   <= 32'd0;
        end else if (stall) begin
            ctrl_q <= ctrl_q;
        end else if (hazard || !id_valid) begin
            ctrl_q <= '0;
            op_q   <= ALU_NOP;
            a_q    <= 32'd0;
            b_q    <= 32'd0;
            rd_q   <= 5'd0;
            sd_q   <= 32'd0;
        end else begin
            ctrl_q <= dec_ctrl;
            op_q   <= dec_op;
            a_q    <= dec_known ? rs_val : 32'd0;
            b_q    <= b_val;
            rd_q   <= dec_rd;
            sd_q   <= dec_store ? st_val : 32'd0;
        end
    end

    assign ex_valid      = ctrl_q.valid;
    assign ex_reg_write  = ctrl_q.reg_write;
    assign ex_mem_read   = ctrl_q.mem_read;
    assign ex_mem_write  = ctrl_q.mem_write;
    assign ex_branch     = ctrl_q.branch;
    assign ex_alu_op     = op_q;
    assign ex_a          = a_q;
    assign ex_b          = b_q;
    assign ex_rd         = rd_q;
    assign ex_store_data = sd_q;

endmodule

// File: tb/tb_ex_issue.sv
// Scoreboard bench for ex_issue: a behavioural model predicts each cycle's EX
// register contents and hazard_stall; a separate monitor compares the DUT.
module tb_ex_issue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid = 1'b0;
    logic [31:0] id_instr = '0, id_rs_data = '0, id_rt_data = '0, alu_c = '0;
    logic        mem_reg_write = 1'b0, wb_reg_write = 1'b0;
    logic [4:0]  mem_rd = '0, wb_rd = '0;
    logic [31:0] mem_result = '0, wb_result = '0;
    logic        stall = 1'b0, flush = 1'b0;
    logic        hazard_stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch;
    logic [3:0]  ex_alu_op;
    logic [31:0] ex_a, ex_b, ex_store_data;
    logic [4:0]  ex_rd;

    ex_issue dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .alu_c(alu_c),
        .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
        .stall(stall), .flush(flush), .hazard_stall(hazard_stall),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_branch(ex_branch), .ex_alu_op(ex_alu_op),
        .ex_a(ex_a), .ex_b(ex_b), .ex_rd(ex_rd), .ex_store_data(ex_store_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid, rw, mr, mw, br;
        logic [3:0]  op;
        logic [31:0] a, b;
        logic [4:0]  rd;
        logic [31:0] sd;
    } exp_t;

    typedef struct packed {
        logic hz;
        exp_t st;
    } entry_t;

    typedef struct {
        logic        rst, v;
        logic [31:0] instr, rsd, rtd, aluc;
        logic        mrw;
        logic [4:0]  mrd;
        logic [31:0] mres;
        logic        wrw;
        logic [4:0]  wrd;
        logic [31:0] wres;
        logic        st, fl;
    } stim_t;

    entry_t sb_q[$];
    exp_t   model_ex = '0;
    int     checks = 0, passed = 0;
    bit     stim_done = 0, mon_done = 0;

    function automatic logic [31:0] r_type(input logic [5:0] fn, input logic [4:0] s, t, d);
        return {6'd0, s, t, d, 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] s, t,
                                           input logic [15:0] imm);
        return {op, s, t, imm};
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '{rst: 0, v: 0, instr: 0, rsd: 0, rtd: 0, aluc: 0, mrw: 0, mrd: 0, mres: 0,
              wrw: 0, wrd: 0, wres: 0, st: 0, fl: 0};
        return s;
    endfunction

    // Value an instruction would see for register r after considering in-flight writers.
    function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] rf, input stim_t s);
        if (r == 0) return 32'd0;
        if (model_ex.valid && model_ex.rw && !model_ex.mr && model_ex.rd == r) return s.aluc;
        if (s.mrw && s.mrd == r) return s.mres;
        if (s.wrw && s.wrd == r) return s.wres;
        return rf;
    endfunction

    function automatic exp_t decode(input stim_t s);
        exp_t e;
        logic [5:0] op, fn;
        logic [4:0] rs, rt;
        logic [15:0] imm;
        logic [31:0] a, b;
        op = s.instr[31:26]; fn = s.instr[5:0];
        rs = s.instr[25:21]; rt = s.instr[20:16]; imm = s.instr[15:0];
        a = operand(rs, s.rsd, s);
        b = operand(rt, s.rtd, s);
        e = '0;
        e.valid = 1;
        if (op == 6'h00 && fn == 6'h21) begin
            e.op = 4'b0010; e.a = a; e.b = b; e.rd = s.instr[15:11]; e.rw = 1;
        end else if (op == 6'h00 && fn == 6'h23) begin
            e.op = 4'b0110; e.a = a; e.b = b; e.rd = s.instr[15:11]; e.rw = 1;
        end else if (op == 6'h0d) begin
            e.op = 4'b0001; e.a = a; e.b = {16'd0, imm}; e.rd = rt; e.rw = 1;
        end else if (op == 6'h0f) begin
            e.op = 4'b1000; e.a = a; e.b = {16'd0, imm}; e.rd = rt; e.rw = 1;
        end else if (op == 6'h23) begin
            e.op = 4'b0010; e.a = a; e.b = $signed(imm); e.rd = rt; e.rw = 1; e.mr = 1;
        end else if (op == 6'h2b) begin
            e.op = 4'b0010; e.a = a; e.b = $signed(imm); e.mw = 1; e.sd = b;
        end else if (op == 6'h04) begin
            e.op = 4'b0110; e.a = a; e.b = b; e.br = 1;
        end
        return e;
    endfunction

    function automatic logic uses_rt(input logic [31:0] instr);
        logic [5:0] op;
        op = instr[31:26];
        return (op == 6'h00 && (instr[5:0] == 6'h21 || instr[5:0] == 6'h23)) ||
               op == 6'h2b || op == 6'h04;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic applyStimulus(input stim_t s);
        logic  hz;
        exp_t  nxt;
        entry_t ent;
        @(negedge clk);
        #1;
        rst = s.rst; id_valid = s.v; id_instr = s.instr; id_rs_data = s.rsd; id_rt_data = s.rtd;
        alu_c = s.aluc; mem_reg_write = s.mrw; mem_rd = s.mrd; mem_result = s.mres;
        wb_reg_write = s.wrw; wb_rd = s.wrd; wb_result = s.wres; stall = s.st; flush = s.fl;
        hz = model_ex.valid && model_ex.mr && model_ex.rd != 0 && s.v &&
             (s.instr[25:21] == model_ex.rd || (uses_rt(s.instr) && s.instr[20:16] == model_ex.rd));
        if (s.rst || s.fl) nxt = '0;
        else if (s.st)     nxt = model_ex;
        else if (hz || !s.v) nxt = '0;
        else               nxt = decode(s);
        ent.hz = hz && !s.fl && !s.rst;
        ent.st = nxt;
        sb_q.push_back(ent);
        model_ex = nxt;
    endtask

    function automatic stim_t random_stim();
        stim_t s;
        logic [4:0] a, b, d;
        logic [15:0] imm;
        s = idle();
        a = 5'($urandom_range(0, 7)); b = 5'($urandom_range(0, 7)); d = 5'($urandom_range(0, 7));
        imm = 16'($urandom);
        case ($urandom_range(0, 9))
            0, 1: s.instr = r_type(6'h21, a, b, d);
            2:    s.instr = r_type(6'h23, a, b, d);
            3:    s.instr = i_type(6'h0d, a, b, imm);
            4:    s.instr = i_type(6'h0f, a, b, imm);
            5, 6: s.instr = i_type(6'h23, a, b, imm);
            7:    s.instr = i_type(6'h2b, a, b, imm);
            8:    s.instr = i_type(6'h04, a, b, imm);
            default: s.instr = ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom;
        endcase
        s.v    = ($urandom_range(0, 9) != 0);
        s.rsd  = $urandom; s.rtd = $urandom; s.aluc = $urandom;
        s.mrw  = $urandom_range(0, 1) == 1; s.mrd = 5'($urandom_range(0, 7)); s.mres = $urandom;
        s.wrw  = $urandom_range(0, 1) == 1; s.wrd = 5'($urandom_range(0, 7)); s.wres = $urandom;
        s.st   = ($urandom_range(0, 7) == 0);
        s.fl   = ($urandom_range(0, 11) == 0);
        s.rst  = ($urandom_range(0, 63) == 0);
        return s;
    endfunction

    // Monitor: combinational hazard_stall mid-cycle, registered state just after the edge.
    initial begin : monitor
        entry_t ent;
        exp_t   act;
        forever begin
            @(negedge clk);
            #3;
            if (sb_q.size() == 0) begin
                if (stim_done) break;
                continue;
            end
            ent = sb_q.pop_front();
            checkOutput("hazard_stall", 128'(hazard_stall), 128'(ent.hz));
            @(posedge clk);
            #1;
            act = '{valid: ex_valid, rw: ex_reg_write, mr: ex_mem_read, mw: ex_mem_write,
                    br: ex_branch, op: ex_alu_op, a: ex_a, b: ex_b, rd: ex_rd, sd: ex_store_data};
            checkOutput("ex_state", 128'(act), 128'(ent.st));
        end
        mon_done = 1;
    end

    initial begin : stimulus
        stim_t s;
        for (int i = 0; i < 2; i++) begin
            s = random_stim();
            s.rst = 1; s.v = 1; s.st = 0; s.fl = 0;
            applyStimulus(s);
        end
        applyStimulus(idle());

        s = idle(); s.v = 1; s.instr = r_type(6'h21, 5'd1, 5'd2, 5'd3); s.rsd = 5; s.rtd = 7;
        applyStimulus(s);
        s = idle(); s.v = 1; s.instr = i_type(6'h0f, 5'd0, 5'd4, 16'h1234);
        applyStimulus(s);

        s = idle(); s.v = 1; s.instr = r_type(6'h21, 5'd1, 5'd2, 5'd3); s.rsd = 1; s.rtd = 2;
        applyStimulus(s);
        s = idle(); s.v = 1; s.instr = r_type(6'h23, 5'd3, 5'd3, 5'd5); s.aluc = 32'h0C;
        s.mrw = 1; s.mrd = 3; s.mres = 32'h99; s.rsd = 32'hdead; s.rtd = 32'hbeef;
        applyStimulus(s);

        s = idle(); s.v = 1; s.instr = i_type(6'h23, 5'd1, 5'd2, 16'd4); s.rsd = 32'h100;
        applyStimulus(s);
        s = idle(); s.v = 1; s.instr = r_type(6'h21, 5'd2, 5'd2, 5'd6); s.rsd = 1; s.rtd = 1;
        applyStimulus(s);
        s.mrw = 1; s.mrd = 2; s.mres = 32'h55;
        applyStimulus(s);

        s = idle(); s.v = 1; s.instr = i_type(6'h0d, 5'd1, 5'd7, 16'h00f0); s.rsd = 32'h0f;
        s.st = 1; s.fl = 1;
        applyStimulus(s);
        s.st = 0; s.fl = 0;
        applyStimulus(s);
        for (int i = 0; i < 3; i++) begin
            s = random_stim();
            s.rst = 0; s.fl = 0; s.st = 1;
            applyStimulus(s);
        end

        s = idle(); s.v = 1; s.instr = i_type(6'h2b, 5'd0, 5'd0, 16'hfffc); s.rtd = 32'h1234;
        applyStimulus(s);

        for (int i = 0; i < 400; i++) applyStimulus(random_stim());
        stim_done = 1;
    end

    initial begin : finisher
        fork
            wait (mon_done);
            #100000;
        join_any
        if (!mon_done) begin
            checks++;
            $display("[TB] FAIL timeout: monitor did not drain scoreboard, %0d entries left", sb_q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
